// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared types and constants for the round-robin bus controller
package rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_N        = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set req bit at or after ptr, wrapping
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            valid_o,
    output logic [ID_W-1:0] idx_o
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr_i));
        end
        masked  = req_i & mask;
        valid_o = |req_i;
        idx_o   = '0;
        // Scanning downward lets the lowest set bit win the last assignment.
        if (|masked) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (masked[i]) idx_o = ID_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_bus_controller.sv
// rtl/rr_bus_controller.sv - round-robin shared-bus arbiter with grant locking and a release gap
// Optional hold-tenure limit and preempted pulse are built when HOLD_LIMIT_EN is defined.
module rr_bus_controller
    import rr_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             req,
    input  logic [N-1:0]             done,
    output logic [N-1:0]             grant,
    output logic [id_width(N)-1:0]   grant_id,
    output logic                     busy,
    output logic                     preempted
);

    localparam int ID_W = id_width(N);
    localparam int HC_W = id_width(MAX_HOLD);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              busy_q, busy_d;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic              owner_req;
    logic              owner_done;
    logic              hold_hit;
    logic              rel_now;

`ifdef HOLD_LIMIT_EN
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              preempted_q, preempted_d;
`endif

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        owner_req  = req[grant_id_q];
        owner_done = done[grant_id_q];
`ifdef HOLD_LIMIT_EN
        hold_cnt_d  = hold_cnt_q;
        preempted_d = 1'b0;
        hold_hit    = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
`else
        hold_hit    = 1'b0;
`endif
        rel_now = !owner_req || owner_done || hold_hit;

        case (state_q)
            IDLE, GAP: begin
                if (pick_valid) begin
                    state_d             = GRANT;
                    grant_d             = '0;
                    grant_d[pick_idx]   = 1'b1;
                    grant_id_d          = pick_idx;
                    busy_d              = 1'b1;
`ifdef HOLD_LIMIT_EN
                    hold_cnt_d          = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (rel_now) begin
                    state_d = GAP;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    // Former owner drops to lowest priority at the next pick.
                    ptr_d   = (grant_id_q == ID_W'(N - 1)) ? '0 : grant_id_q + ID_W'(1);
`ifdef HOLD_LIMIT_EN
                    preempted_d = hold_hit && owner_req && !owner_done;
`endif
                end else begin
`ifdef HOLD_LIMIT_EN
                    if (hold_cnt_q != HC_W'(MAX_HOLD - 1)) hold_cnt_d = hold_cnt_q + HC_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

`ifdef HOLD_LIMIT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q  <= '0;
            preempted_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            preempted_q <= preempted_d;
        end
    end

    assign preempted = preempted_q;
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^{HC_W[0], MAX_HOLD[0]};
    assign preempted       = 1'b0;
`endif

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rr_bus_controller.sv
// tb/tb_rr_bus_controller.sv - scoreboard bench with a round-robin reference model for rr_bus_controller
module tb_rr_bus_controller;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int ID_W     = 2;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    done  = '0;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic            preempted;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [N-1:0]    grant;
        logic [ID_W-1:0] id;
        logic            busy;
        logic            pre;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: owner index (-1 = nobody), next-priority pointer, tenure, last owner.
    int   m_owner;
    int   m_ptr;
    int   m_ten;
    int   m_last;
    logic m_pre;

    always #5 clk = ~clk;

    rr_bus_controller #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .preempted (preempted)
    );

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ten   = 0;
        m_last  = 0;
        m_pre   = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit hit;
        int i;
        hit   = 1'b0;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
`ifdef HOLD_LIMIT_EN
            hit = (m_ten == MAX_HOLD - 1);
`endif
            if (!r[m_owner] || d[m_owner] || hit) begin
                m_pre   = hit && r[m_owner] && !d[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_ten++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (m_owner < 0 && r[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_ten   = 0;
                end
            end
        end
    endfunction

    task automatic push_step(input logic [N-1:0] r, input logic [N-1:0] d);
        exp_t         e;
        logic [N-1:0] one;
        one  = 1;
        req  = r;
        done = d;
        model_step(r, d);
        e.grant = (m_owner >= 0) ? (one << m_owner) : '0;
        e.id    = ID_W'(m_last);
        e.busy  = (m_owner >= 0);
        e.pre   = m_pre;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        @(posedge clk);
        #2;
        push_step(r, d);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (grant === e.grant && grant_id === e.id && busy === e.busy && preempted === e.pre) begin
                    n_pass++;
                end else begin
                    $display("FAIL scoreboard t=%0t: grant=%b id=%0d busy=%b pre=%b expected grant=%b id=%0d busy=%b pre=%b",
                             $time, grant, grant_id, busy, preempted, e.grant, e.id, e.busy, e.pre);
                end
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] r_cur;
        logic [N-1:0] d_cur;

        req = 4'b0100;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_grant_id", 32'(grant_id), 32'h0);
        chk("reset_preempted", 32'(preempted), 32'h0);
        model_reset();

        @(posedge clk);
        #2;
        reset = 1'b1;
        push_step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Lock: owner 0 keeps the bus while everyone requests, then drops.
        step(4'b0001, 4'b0000);
        repeat (5) step(4'b1111, 4'b0000);
        repeat (3) step(4'b1110, 4'b0000);
        step(4'b1000, 4'b0000);
        repeat (3) step(4'b1000, 4'b0000);

        // Wrap-around: owner 3 finishes via done with 0 and 3 requesting.
        step(4'b1001, 4'b1000);
        repeat (3) step(4'b1001, 4'b0000);
        step(4'b0000, 4'b0000);

        // Sole requester is re-granted after the gap.
        repeat (3) step(4'b0010, 4'b0000);
        step(4'b0010, 4'b0010);
        repeat (3) step(4'b0010, 4'b0000);
        step(4'b0000, 4'b0000);

        // Continuous two-way contention exercises the hold limit when built in.
        repeat (14) step(4'b0011, 4'b0000);
        repeat (2) step(4'b0000, 4'b0000);

        // Asynchronous reset between edges while 3 owns the bus.
        repeat (2) step(4'b1000, 4'b0000);
        @(posedge clk);
        #3;
        chk("pre_reset_grant", 32'(grant), 32'h8);
        reset = 1'b0;
        #1;
        chk("async_reset_grant", 32'(grant), 32'h0);
        chk("async_reset_busy", 32'(busy), 32'h0);
        chk("async_reset_grant_id", 32'(grant_id), 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        push_step(4'b1000, 4'b0000);
        step(4'b1000, 4'b0000);
        @(posedge clk);
        #3;
        chk("post_reset_grant", 32'(grant), 32'h8);
        #1;
        push_step(4'b0000, 4'b0000);

        r_cur = '0;
        for (int c = 0; c < 600; c++) begin
            d_cur = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r_cur[b] = ~r_cur[b];
                if ($urandom_range(0, 7) == 0) d_cur[b] = 1'b1;
            end
            step(r_cur, d_cur);
        end
        step(4'b0000, 4'b0000);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_bus_controller.md
Name: rr_bus_controller

Overview:
- Time-multiplexes one shared bus/resource among N requesters using round-robin arbitration with grant locking.
- A winner holds its grant until it drops req, pulses done, or hits an optional hold limit.
- A one-cycle gap follows every release before the next grant.
- Sits between requester masters and the shared datapath.
- Drives the bus mux select (grant_id) and per-master grant lines.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum grant tenure in cycles. Used only with HOLD_LIMIT_EN.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  N  per-requester request level; held high while the requester wants or uses the bus.
- done  input  N  per-requester end-of-transfer pulse; only the bit of the current owner is honoured.
- grant  output  N  registered, one-hot or zero; the current owner.
- grant_id  output  $clog2(N)  registered index of the owner; mux select for the datapath.
- busy  output  1  registered; high while any grant is asserted.
- preempted  output  1  registered one-cycle pulse when a grant is revoked by the hold limit. Constant 0 without HOLD_LIMIT_EN.

Behaviour:
- Reset values while reset=0, applied asynchronously:
  - grant=0, grant_id=0, busy=0, preempted=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant drops grant immediately, with no gap cycle.
- State IDLE (grant=0):
  - If req!=0, pick the winner W and go to GRANT.
  - Next cycle: grant=1<<W, grant_id=W, busy=1, hold_cnt=0.
  - Latency from req rising to grant is 1 cycle.
- Round-robin pick:
  - Choose the first set bit of req scanning ptr, ptr+1, …, N-1, then 0, …, ptr-1.
  - Mask form: masked = req & ~((1<<ptr)-1). If masked!=0, use the lowest set bit of masked; otherwise the lowest set bit of req.
- State GRANT (owner O), per cycle:
  - Release condition: req[O]==0, OR done[O]==1, OR (HOLD_LIMIT_EN and hold_cnt==MAX_HOLD-1).
  - On release: go to GAP; next cycle grant=0, busy=0, ptr=(O+1) mod N (wraps N-1 to 0).
  - Otherwise: hold_cnt += 1, saturating at MAX_HOLD-1.
  - Requests and done from non-owners are ignored.
  - req drop and done in the same cycle produce a single release.
- State GAP (grant=0, busy=0):
  - Arbitrate using the updated ptr.
  - If req!=0, go to GRANT with the new winner next cycle; otherwise go to IDLE.
  - Release-to-next-grant spacing is exactly 1 idle cycle.
- Former owner:
  - Has the lowest priority at the next arbitration.
  - If it is the only requester, it is re-granted after the gap.
- grant_id holds its last value while grant=0.
- preempted pulses for the single cycle in which the GAP state is entered due to the hold limit.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - The hold_cnt limit forces release after MAX_HOLD cycles of tenure.
  - preempted is driven as described above.
- Undefined:
  - No hold counter is implemented.
  - Grant is held indefinitely until req drop or done.
  - preempted is tied to 0.

Decomposition:
- Package rr_pkg:
  - State typedef {IDLE, GRANT, GAP}.
  - Default N and MAX_HOLD constants.
  - ID-width function.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req[N], ptr.
  - Outputs: valid, idx.
  - Mask plus lowest-set-bit logic, instantiated once.

Test Plan:
- Reset and single request: reset low with req=4'b0100, then reset high → grant=0 during reset; grant=4'b0100, grant_id=2, busy=1 one cycle after release.
- Lock: owner 0 holds req while req=4'b1111 for 5 cycles → grant stays 4'b0001. Owner drops req → one cycle grant=0, then grant=4'b0010.
- Wrap-around: owner 3 releases via done pulse with req=4'b1001 → gap cycle, then grant=4'b0001 (ptr wrapped to 0).
- Hold limit (HOLD_LIMIT_EN, MAX_HOLD=4): req=4'b0011 held continuously → grant 4'b0001 for exactly 4 cycles, preempted=1 for 1 cycle, gap, then 4'b0010 for 4 cycles. Without the macro, 4'b0001 is held indefinitely.
- Sole requester re-grant: only req[1] high; done[1] pulses → grant 0 for 1 cycle, then 4'b0010 again.
- Async reset mid-grant: reset low between clock edges while grant=4'b1000 → grant=0 and busy=0 immediately. After release with req=4'b1000 → grant=4'b1000 one cycle later (ptr=0).
